// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: resolves branches, runs the req/ack handshake to a
// multi-cycle data memory, stalls the front of the pipeline while an access
// is outstanding and drives the MEM/WB register (bubbles while stalled).
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] fourPC,
    input  logic [1:0]  branch,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memToReg,
    input  logic        regWrite,
    input  logic [31:0] beqInstruction,
    input  logic        zero,
    input  logic [31:0] aluResult,
    input  logic [31:0] readData2,
    input  logic [5:0]  writeDataReg,
    output logic        stall,
    output logic        pcSrc,
    output logic [31:0] pcTarget,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:2] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        bus_err,
    output logic        misalign,
    output logic        wb_regWrite,
    output logic [1:0]  wb_memToReg,
    output logic [31:0] wb_readData,
    output logic [31:0] wb_aluResult,
    output logic [5:0]  wb_writeDataReg,
    output logic [31:2] wb_fourPC
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, next_state;
    logic [7:0]  count, next_count;
    logic [31:2] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        access, acc, bad, taken;
    logic        ack_done, timed_out;

    assign access = memRead | memWrite;
    assign acc    = access & (aluResult[1:0] == 2'b00);
    assign bad    = access & (aluResult[1:0] != 2'b00);

    // Branch is resolved combinationally; the redirect is held off while the
    // instruction is still stalled so it fires only in its release cycle.
    assign taken    = ((branch == 2'b01) & zero) | ((branch == 2'b10) & ~zero);
    assign pcSrc    = taken & ~stall;
    assign pcTarget = beqInstruction;

    // State and wait-cycle counter; reset drops the request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 8'd0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state, handshake outputs, stall and error pulses.
    always_comb begin
        next_state = state;
        next_count = count;
        stall      = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        bus_err    = 1'b0;
        misalign   = 1'b0;
        ack_done   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (acc) begin
                        stall      = 1'b1;
                        next_state = WAIT;
                        next_count = 8'd1;
                    end else if (bad) begin
                        misalign = 1'b1;
                    end
                end
            end
            WAIT: begin
                dm_req   = 1'b1;
                dm_we    = we_q;
                dm_addr  = addr_q;
                dm_wdata = wdata_q;
                if (dm_ack) begin
                    ack_done   = 1'b1;
                    next_state = IDLE;
                    next_count = 8'd0;
                end else if (count == TIMEOUT_CNT) begin
                    timed_out  = 1'b1;
                    bus_err    = 1'b1;
                    next_state = IDLE;
                    next_count = 8'd0;
                end else begin
                    stall      = 1'b1;
                    next_count = count + 8'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture address, direction and write data when an access starts so the
    // bus stays stable for the whole WAIT period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (state == IDLE && acc) begin
            addr_q  <= aluResult[31:2];
            we_q    <= memWrite & ~memRead;
            wdata_q <= readData2;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise pass the instruction
    // on; failed loads (timeout or misaligned) must not write the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regWrite     <= 1'b0;
            wb_memToReg     <= 2'b00;
            wb_readData     <= '0;
            wb_aluResult    <= '0;
            wb_writeDataReg <= '0;
            wb_fourPC       <= '0;
        end else if (stall) begin
            wb_regWrite     <= 1'b0;
            wb_memToReg     <= 2'b00;
            wb_readData     <= '0;
            wb_aluResult    <= '0;
            wb_writeDataReg <= '0;
            wb_fourPC       <= '0;
        end else begin
            wb_regWrite     <= regWrite & ~(memRead & (bad | timed_out));
            wb_memToReg     <= memToReg;
            wb_readData     <= (memRead & ack_done) ? dm_rdata : 32'd0;
            wb_aluResult    <= aluResult;
            wb_writeDataReg <= writeDataReg;
            wb_fourPC       <= fourPC;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT = 16).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:2] fourPC;
    logic [1:0]  branch;
    logic        memRead, memWrite;
    logic [1:0]  memToReg;
    logic        regWrite;
    logic [31:0] beqInstruction;
    logic        zero;
    logic [31:0] aluResult, readData2;
    logic [5:0]  writeDataReg;
    logic        stall, pcSrc;
    logic [31:0] pcTarget;
    logic        dm_req, dm_we;
    logic [31:2] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        bus_err, misalign;
    logic        wb_regWrite;
    logic [1:0]  wb_memToReg;
    logic [31:0] wb_readData, wb_aluResult;
    logic [5:0]  wb_writeDataReg;
    logic [31:2] wb_fourPC;

    int tests  = 0;
    int errors = 0;

    mem_stage_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .fourPC(fourPC), .branch(branch),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .regWrite(regWrite), .beqInstruction(beqInstruction), .zero(zero),
        .aluResult(aluResult), .readData2(readData2), .writeDataReg(writeDataReg),
        .stall(stall), .pcSrc(pcSrc), .pcTarget(pcTarget),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .bus_err(bus_err), .misalign(misalign),
        .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
        .wb_readData(wb_readData), .wb_aluResult(wb_aluResult),
        .wb_writeDataReg(wb_writeDataReg), .wb_fourPC(wb_fourPC)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        fourPC = '0; branch = 2'b00; memRead = 0; memWrite = 0; memToReg = 2'b00;
        regWrite = 0; beqInstruction = '0; zero = 0; aluResult = '0;
        readData2 = '0; writeDataReg = '0; dm_rdata = '0; dm_ack = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        tests++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
        tests++; if (dm_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_dm_req: got %0b expected 0", dm_req); end
        tests++; if (wb_regWrite !== 1'b0 || wb_aluResult !== 32'd0 || wb_readData !== 32'd0)
            begin errors++; $display("[TB] FAIL reset_wb: got rw=%0b alu=%h rd=%h expected 0/0/0", wb_regWrite, wb_aluResult, wb_readData); end
        tests++; if (bus_err !== 1'b0 || misalign !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_err: got bus_err=%0b misalign=%0b expected 0/0", bus_err, misalign); end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_load();
        memRead = 1; regWrite = 1; memToReg = 2'b01; aluResult = 32'h0000_0010;
        writeDataReg = 6'd5; fourPC = 30'h0000_0041;
        #1;
        tests++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL load_stall_idle: got %0b expected 1", stall); end
        tests++; if (dm_req !== 1'b0) begin errors++; $display("[TB] FAIL load_req_idle: got %0b expected 0", dm_req); end
        next_cycle();
        tests++; if (dm_req !== 1'b1 || dm_addr !== 30'h4 || dm_we !== 1'b0)
            begin errors++; $display("[TB] FAIL load_bus: got req=%0b addr=%h we=%0b expected 1/4/0", dm_req, dm_addr, dm_we); end
        tests++; if (wb_regWrite !== 1'b0) begin errors++; $display("[TB] FAIL load_bubble: got %0b expected 0", wb_regWrite); end
        dm_ack = 1; dm_rdata = 32'hCAFE_F00D;
        #1;
        tests++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL load_release: got %0b expected 0", stall); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (wb_readData !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL load_rdata: got %h expected cafef00d", wb_readData); end
        tests++; if (wb_regWrite !== 1'b1 || wb_memToReg !== 2'b01 || wb_writeDataReg !== 6'd5 || wb_fourPC !== 30'h41)
            begin errors++; $display("[TB] FAIL load_pass: got rw=%0b m2r=%0d rd=%0d pc=%h expected 1/1/5/41", wb_regWrite, wb_memToReg, wb_writeDataReg, wb_fourPC); end
        tests++; if (dm_req !== 1'b0) begin errors++; $display("[TB] FAIL load_idle_after: got %0b expected 0", dm_req); end
    endtask

    task automatic test_store_delayed_ack();
        int stall_cycles = 0;
        memWrite = 1; regWrite = 1; aluResult = 32'h20; readData2 = 32'h1234_5678;
        #1;
        if (stall === 1'b1) stall_cycles++;
        next_cycle();
        tests++; if (wb_regWrite !== 1'b0 || wb_aluResult !== 32'd0)
            begin errors++; $display("[TB] FAIL store_bubble0: got rw=%0b alu=%h expected 0/0", wb_regWrite, wb_aluResult); end
        for (int c = 1; c <= 4; c++) begin
            dm_ack = (c == 4);
            #1;
            if (stall === 1'b1) stall_cycles++;
            tests++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 30'h8 || dm_wdata !== 32'h1234_5678)
                begin errors++; $display("[TB] FAIL store_bus_c%0d: got req=%0b we=%0b addr=%h wd=%h expected 1/1/8/12345678", c, dm_req, dm_we, dm_addr, dm_wdata); end
            next_cycle();
            if (c < 4) begin
                tests++; if (wb_regWrite !== 1'b0 || wb_aluResult !== 32'd0)
                    begin errors++; $display("[TB] FAIL store_bubble%0d: got rw=%0b alu=%h expected 0/0", c, wb_regWrite, wb_aluResult); end
            end
        end
        clear_inputs();
        #1;
        tests++; if (stall_cycles != 4) begin errors++; $display("[TB] FAIL store_stall_len: got %0d expected 4", stall_cycles); end
        tests++; if (wb_regWrite !== 1'b1 || wb_aluResult !== 32'h20 || wb_readData !== 32'd0)
            begin errors++; $display("[TB] FAIL store_release: got rw=%0b alu=%h rd=%h expected 1/20/0", wb_regWrite, wb_aluResult, wb_readData); end
    endtask

    task automatic test_timeout();
        memRead = 1; regWrite = 1; aluResult = 32'h40; writeDataReg = 6'd9; dm_rdata = 32'hDEAD_BEEF;
        next_cycle();
        for (int c = 1; c <= 16; c++) begin
            tests++; if (dm_req !== 1'b1 || bus_err !== (c == 16) || stall !== (c != 16))
                begin errors++; $display("[TB] FAIL timeout_c%0d: got req=%0b err=%0b stall=%0b expected 1/%0b/%0b", c, dm_req, bus_err, stall, c == 16, c != 16); end
            next_cycle();
        end
        clear_inputs();
        #1;
        tests++; if (wb_regWrite !== 1'b0 || wb_readData !== 32'd0 || wb_aluResult !== 32'h40)
            begin errors++; $display("[TB] FAIL timeout_wb: got rw=%0b rd=%h alu=%h expected 0/0/40", wb_regWrite, wb_readData, wb_aluResult); end
        tests++; if (dm_req !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("[TB] FAIL timeout_idle: got req=%0b err=%0b stall=%0b expected 0/0/0", dm_req, bus_err, stall); end
    endtask

    task automatic test_misalign();
        memRead = 1; regWrite = 1; aluResult = 32'h13;
        #1;
        tests++; if (misalign !== 1'b1 || stall !== 1'b0 || dm_req !== 1'b0)
            begin errors++; $display("[TB] FAIL misalign_pulse: got mis=%0b stall=%0b req=%0b expected 1/0/0", misalign, stall, dm_req); end
        next_cycle();
        tests++; if (wb_regWrite !== 1'b0 || dm_req !== 1'b0)
            begin errors++; $display("[TB] FAIL misalign_wb: got rw=%0b req=%0b expected 0/0", wb_regWrite, dm_req); end
        clear_inputs();
        memWrite = 1; aluResult = 32'h22; readData2 = 32'hFFFF_FFFF;
        #1;
        tests++; if (misalign !== 1'b1 || dm_req !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("[TB] FAIL misalign_store: got mis=%0b req=%0b stall=%0b expected 1/0/0", misalign, dm_req, stall); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (misalign !== 1'b0 || dm_req !== 1'b0)
            begin errors++; $display("[TB] FAIL misalign_clear: got mis=%0b req=%0b expected 0/0", misalign, dm_req); end
    endtask

    task automatic test_branch();
        branch = 2'b01; zero = 1; beqInstruction = 32'h400;
        #1;
        tests++; if (pcSrc !== 1'b1 || pcTarget !== 32'h400)
            begin errors++; $display("[TB] FAIL beq_taken: got src=%0b tgt=%h expected 1/400", pcSrc, pcTarget); end
        zero = 0; #1;
        tests++; if (pcSrc !== 1'b0) begin errors++; $display("[TB] FAIL beq_not_taken: got %0b expected 0", pcSrc); end
        branch = 2'b10; zero = 1; #1;
        tests++; if (pcSrc !== 1'b0) begin errors++; $display("[TB] FAIL bne_zero: got %0b expected 0", pcSrc); end
        zero = 0; #1;
        tests++; if (pcSrc !== 1'b1) begin errors++; $display("[TB] FAIL bne_taken: got %0b expected 1", pcSrc); end
        branch = 2'b11; zero = 1; #1;
        tests++; if (pcSrc !== 1'b0) begin errors++; $display("[TB] FAIL br11_z1: got %0b expected 0", pcSrc); end
        zero = 0; #1;
        tests++; if (pcSrc !== 1'b0) begin errors++; $display("[TB] FAIL br11_z0: got %0b expected 0", pcSrc); end
        branch = 2'b01; zero = 1; memRead = 1; aluResult = 32'h80; #1;
        tests++; if (pcSrc !== 1'b0) begin errors++; $display("[TB] FAIL beq_stalled: got %0b expected 0", pcSrc); end
        next_cycle();
        dm_ack = 1; #1;
        tests++; if (pcSrc !== 1'b1) begin errors++; $display("[TB] FAIL beq_release: got %0b expected 1", pcSrc); end
        next_cycle();
        clear_inputs();
        #1;
    endtask

    task automatic test_reset_mid_wait();
        memRead = 1; regWrite = 1; aluResult = 32'h100;
        next_cycle();
        tests++; if (dm_req !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_req_before: got %0b expected 1", dm_req); end
        rst = 1'b1;
        #1;
        tests++; if (dm_req !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("[TB] FAIL rstwait_async: got req=%0b stall=%0b expected 0/0", dm_req, stall); end
        tests++; if (wb_regWrite !== 1'b0 || wb_aluResult !== 32'd0 || wb_fourPC !== 30'd0)
            begin errors++; $display("[TB] FAIL rstwait_wb: got rw=%0b alu=%h pc=%h expected 0/0/0", wb_regWrite, wb_aluResult, wb_fourPC); end
        next_cycle();
        tests++; if (dm_req !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_held: got %0b expected 0", dm_req); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        memRead = 1; regWrite = 1; aluResult = 32'h0000_0104; writeDataReg = 6'd7;
        #1;
        tests++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_restart: got %0b expected 1", stall); end
        next_cycle();
        tests++; if (dm_req !== 1'b1 || dm_addr !== 30'h41)
            begin errors++; $display("[TB] FAIL rstwait_bus: got req=%0b addr=%h expected 1/41", dm_req, dm_addr); end
        dm_ack = 1; dm_rdata = 32'h0BAD_CAFE;
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (wb_readData !== 32'h0BAD_CAFE || wb_regWrite !== 1'b1 || wb_writeDataReg !== 6'd7)
            begin errors++; $display("[TB] FAIL rstwait_load: got rd=%h rw=%0b dst=%0d expected 0badcafe/1/7", wb_readData, wb_regWrite, wb_writeDataReg); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_delayed_ack();
        test_timeout();
        test_misalign();
        test_branch();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
